// File: rtl/ccff_prog_ctrl.sv
// ccff_prog_ctrl: streams host configuration words MSB-first into a ccff chain.
// Define CCFF_READBACK_EN to add a recirculating CRC-8 readback check (VERIFY state).
module ccff_prog_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_en,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CHAIN_LEN);
  localparam logic [WW-1:0] WCNT_LAST = WW'(WORD_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
`ifdef CCFF_READBACK_EN
    VERIFY = 3'd3,
`endif
    DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [WW-1:0]     wcnt_q, wcnt_d, wcnt_inc;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              head_q, head_d;
  logic              chain_en_q, chain_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

`ifdef CCFF_READBACK_EN
  logic [7:0] crc_ld_q, crc_ld_d, crc_rb_q, crc_rb_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  assign cnt_inc  = cnt_q + CW'(1);
  assign wcnt_inc = wcnt_q + WW'(1);

  // Next-state and next-output logic; outputs are registered for the state being entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    buf_d       = buf_q;
    cfg_ready_d = 1'b0;
    head_d      = 1'b0;
    chain_en_d  = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    err_d       = err_q;
`ifdef CCFF_READBACK_EN
    crc_ld_d    = crc_ld_q;
    crc_rb_d    = crc_rb_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          cnt_d       = {CW{1'b0}};
          err_d       = 1'b0;
          cfg_ready_d = 1'b1;
`ifdef CCFF_READBACK_EN
          crc_ld_d    = 8'h00;
          crc_rb_d    = 8'h00;
`endif
        end else begin
          busy_d = 1'b0;
        end
      end
      LOAD: begin
        if (cfg_valid && cfg_ready_q) begin
          state_d    = SHIFT;
          wcnt_d     = {WW{1'b0}};
          chain_en_d = 1'b1;
          head_d     = cfg_data[WORD_W-1];
          buf_d      = cfg_data << 1;
        end else begin
          cfg_ready_d = 1'b1;
        end
      end
      SHIFT: begin
        cnt_d  = cnt_inc;
        wcnt_d = wcnt_inc;
`ifdef CCFF_READBACK_EN
        crc_ld_d = crc8_step(crc_ld_q, head_q);
`endif
        // Chain full: whatever is left of the current word is dropped.
        if (cnt_inc == CNT_LAST) begin
          buf_d = {WORD_W{1'b0}};
`ifdef CCFF_READBACK_EN
          state_d    = VERIFY;
          cnt_d      = {CW{1'b0}};
          chain_en_d = 1'b1;
`else
          state_d    = DONE;
          done_d     = 1'b1;
`endif
        end else if (wcnt_inc == WCNT_LAST) begin
          state_d     = LOAD;
          cfg_ready_d = 1'b1;
        end else begin
          chain_en_d = 1'b1;
          head_d     = buf_q[WORD_W-1];
          buf_d      = buf_q << 1;
        end
      end
`ifdef CCFF_READBACK_EN
      VERIFY: begin
        cnt_d    = cnt_inc;
        crc_rb_d = crc8_step(crc_rb_q, ccff_tail);
        if (cnt_inc == CNT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = (crc_rb_d != crc_ld_q);
        end else begin
          chain_en_d = 1'b1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      wcnt_q      <= {WW{1'b0}};
      buf_q       <= {WORD_W{1'b0}};
      cfg_ready_q <= 1'b0;
      head_q      <= 1'b0;
      chain_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef CCFF_READBACK_EN
      crc_ld_q    <= 8'h00;
      crc_rb_q    <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      buf_q       <= buf_d;
      cfg_ready_q <= cfg_ready_d;
      head_q      <= head_d;
      chain_en_q  <= chain_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef CCFF_READBACK_EN
      crc_ld_q    <= crc_ld_d;
      crc_rb_q    <= crc_rb_d;
`endif
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign chain_en  = chain_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
`ifdef CCFF_READBACK_EN
  // Recirculation must be same-cycle, so the tail bypasses the head register here.
  assign ccff_head = (state_q == VERIFY) ? ccff_tail : head_q;
`else
  assign ccff_head = head_q;
`endif

endmodule
